message_buffer: RTL and testbench
=================================

MESSAGE_BUFFER -- requirements
Module: message_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of byte slots in one message; legal range 2..14.
REQ-002 Parameter AW, default 4: read-address width; the block SHALL satisfy 2^AW >= DEPTH+2.
REQ-003 Parameter REVERSE, default 1: 1 = read-out in reverse arrival order, 0 = arrival order.
REQ-004 Parameter TERM_EN, default 1: 1 = append "\n" then "\r" after the last byte.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 rx_data  in  8  received byte.
REQ-008 new_rx_data  in  1  byte-valid; level or pulse, edge-detected internally.
REQ-009 clear  in  1  synchronous discard of the current message.
REQ-010 rd_ack  in  1  single-cycle pulse from the printer: message consumed.
REQ-011 rd_addr  in  AW  read character index.
REQ-012 rd_data  out  8  registered read character.
REQ-013 count  out  AW  bytes currently stored, 0..DEPTH.
REQ-014 msg_ready  out  1  high while a complete message is held.
REQ-015 overflow  out  1  sticky: a byte arrived while the buffer was full.

Function
REQ-016 A write event SHALL be detected when new_rx_data is 1 and its value registered on the previous cycle is 0; a held-high level SHALL produce exactly one write.
REQ-017 State machine FILL/READY; reset state FILL.
REQ-018 FILL: a write event SHALL store rx_data at slot[count] and increment count by 1 on the same edge.
REQ-019 FILL: the write that makes count equal DEPTH SHALL move the FSM to READY; msg_ready SHALL be 1 from the following cycle.
REQ-020 READY: write events SHALL be dropped, leave storage and count unchanged, and set overflow.
REQ-021 READY with rd_ack=1: the FSM SHALL go to FILL, set count to 0, and leave slot contents unchanged.
REQ-022 rd_ack in FILL SHALL be ignored.
REQ-023 rd_ack and a write event in the same READY cycle: the ack SHALL be taken, the byte SHALL be dropped, and overflow SHALL be set.
REQ-024 clear=1 in any state: the FSM SHALL go to FILL, set count to 0, and clear overflow; a simultaneous write or rd_ack SHALL be ignored (clear wins).
REQ-025 Read mapping for index i < DEPTH: slot[DEPTH-1-i] when REVERSE=1, slot[i] when REVERSE=0.
REQ-026 Read mapping with TERM_EN=1: i = DEPTH SHALL give 8'h0A and i = DEPTH+1 SHALL give 8'h0D.
REQ-027 Read mapping for every other index, including all indices >= DEPTH when TERM_EN=0, SHALL give 8'h00.
REQ-028 rd_data SHALL reflect rd_addr sampled on the previous edge (latency 1) in both states.
REQ-029 A slot written on the same edge as it is read SHALL return its old content (read-before-write).
REQ-030 count SHALL never exceed DEPTH and SHALL never wrap.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force: FSM=FILL, count=0, msg_ready=0, overflow=0, rd_data=8'h00, all slots=8'h00, registered new_rx_data=0; this holds mid-message and mid-read-out.
REQ-032 After release, the first rising edge of new_rx_data SHALL be a valid write; a new_rx_data level already high at release SHALL also count as one write.

Verification
REQ-033 DEPTH=8, REVERSE=1: write 'A'..'H' -> msg_ready=1 and count=8; read 0..9 -> "HGFEDCBA\n\r"; read 10 -> 8'h00.
REQ-034 REVERSE=0, DEPTH=4, TERM_EN=0: write 'w','x','y','z' -> read 0..4 -> "wxyz", 8'h00.
REQ-035 Full buffer with a 9th write -> overflow=1 and contents unchanged; rd_ack -> count=0, msg_ready=0, overflow still 1; clear -> overflow=0.
REQ-036 new_rx_data held high for 5 cycles -> count increments by exactly 1.
REQ-037 After 3 writes, rst_n low asynchronously mid-cycle -> count=0 and rd_data=8'h00 before the next clk edge; next write lands in slot 0.
REQ-038 Same-cycle clear and write -> count=0 and the byte is not stored; same-cycle rd_ack and write in READY -> count=0 and overflow=1.

Source files
------------

// File: rtl/message_buffer.sv
// Message buffer: collects DEPTH received bytes into a message, holds it for a
// printer that reads it out by character index (optionally reversed and
// terminated with "\n\r"), then releases it on rd_ack.
module message_buffer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 4,
    parameter int REVERSE = 1,
    parameter int TERM_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          new_rx_data,
    input  logic          clear,
    input  logic          rd_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] count,
    output logic          msg_ready,
    output logic          overflow
);

    typedef enum logic {StFill, StReady} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          new_q;
    logic          wr_event;
    logic          wr_en;
    logic [7:0]    slots_q [DEPTH];
    logic [7:0]    rd_data_q;
    logic [7:0]    rd_next;
    int            addr_int;
    int            sel;

    // A write is the rising edge of new_rx_data; a held level writes once.
    assign wr_event = new_rx_data & ~new_q;
    assign addr_int = int'(rd_addr);

    // Previous-cycle copy of new_rx_data for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_q <= 1'b0;
        end else begin
            new_q <= new_rx_data;
        end
    end

    // FSM, count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFill;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic; clear overrides writes and acks in every state.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (clear) begin
            state_d    = StFill;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                StFill: begin
                    // rd_ack is meaningless while filling and is ignored.
                    if (wr_event) begin
                        wr_en   = 1'b1;
                        count_d = count_q + AW'(1);
                        if (count_q == LastIdx) begin
                            state_d = StReady;
                        end
                    end
                end
                StReady: begin
                    // Bytes arriving while a message is held are lost.
                    if (wr_event) begin
                        overflow_d = 1'b1;
                    end
                    if (rd_ack) begin
                        state_d = StFill;
                        count_d = '0;
                    end
                end
            endcase
        end
    end

    // Slot storage; contents survive rd_ack and clear, only reset zeroes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == AW'(i)) begin
                    slots_q[i] <= rx_data;
                end
            end
        end
    end

    // Character index to byte mapping: message body, then optional "\n\r".
    always_comb begin
        rd_next = 8'h00;
        sel     = (REVERSE != 0) ? (DEPTH - 1 - addr_int) : addr_int;
        if (addr_int < DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel == i) begin
                    rd_next = slots_q[i];
                end
            end
        end else if ((TERM_EN != 0) && (addr_int == DEPTH)) begin
            rd_next = 8'h0A;
        end else if ((TERM_EN != 0) && (addr_int == DEPTH + 1)) begin
            rd_next = 8'h0D;
        end
    end

    // Registered read port; old slot content wins on a same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_next;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign msg_ready = (state_q == StReady);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_message_buffer.sv
// Self-checking bench for message_buffer: a DEPTH=8 reversed/terminated
// instance plus a DEPTH=4 in-order/unterminated instance on shared inputs.
module tb_message_buffer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       clear;
    logic       rd_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       msg_ready;
    logic       overflow;
    logic [7:0] rd_data2;
    logic [3:0] count2;
    logic       msg_ready2;
    logic       overflow2;

    int vectors;
    int miscompares;

    // Reference model of the DEPTH=8 instance.
    logic [7:0] m_slots [8];
    logic [3:0] m_count;
    logic       m_ready;
    logic       m_ovf;

    logic [7:0] exp_q [$];
    logic [7:0] got;
    logic [7:0] exp;

    message_buffer #(.DEPTH(8), .AW(4), .REVERSE(1), .TERM_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .clear       (clear),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .count       (count),
        .msg_ready   (msg_ready),
        .overflow    (overflow)
    );

    message_buffer #(.DEPTH(4), .AW(4), .REVERSE(0), .TERM_EN(0)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .clear       (clear),
        .rd_ack      (rd_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data2),
        .count       (count2),
        .msg_ready   (msg_ready2),
        .overflow    (overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_rd(int i);
        if (i < 8) return m_slots[7 - i];
        if (i == 8) return 8'h0A;
        if (i == 9) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_slots[i] = 8'h00;
        m_count = 4'd0;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] b);
        if (!m_ready) begin
            m_slots[m_count[2:0]] = b;
            m_count = m_count + 4'd1;
            if (m_count == 4'd8) m_ready = 1'b1;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        model_write(b);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_count = 4'd0;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_ready = 1'b0;
        m_count = 4'd0;
        m_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx_data = 8'h00; new_rx_data = 1'b0; clear = 1'b0; rd_ack = 1'b0; rd_addr = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({count, msg_ready, overflow, rd_data} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_in: got cnt=%0d rdy=%b ovf=%b rd=%h, want all zero",
                     count, msg_ready, overflow, rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({count, msg_ready, overflow, rd_data} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_out: got cnt=%0d rdy=%b ovf=%b rd=%h, want all zero",
                     count, msg_ready, overflow, rd_data);
        end
    endtask

    task automatic test_fill_reverse();
        for (int i = 0; i < 7; i++) write_byte(8'h41 + 8'(i));
        vectors++;
        if (count !== 4'd7 || msg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill7: got cnt=%0d rdy=%b, want cnt=7 rdy=0", count, msg_ready);
        end
        write_byte(8'h48);
        vectors++;
        if (count !== m_count || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fill8: got cnt=%0d rdy=%b, want cnt=%0d rdy=1", count, msg_ready, m_count);
        end
        for (int i = 0; i <= 11; i++) begin
            @(negedge clk);
            rd_addr = (i == 11) ? 4'd15 : 4'(i);
            exp_q.push_back(model_rd(int'(rd_addr)));
            @(negedge clk);
            got = rd_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rev_read[%0d]: got %h, want %h", rd_addr, got, exp);
            end
        end
    endtask

    task automatic test_overflow();
        write_byte(8'h5A);
        vectors++;
        if (overflow !== 1'b1 || count !== 4'd8 || msg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: got ovf=%b cnt=%0d rdy=%b, want 1 8 1", overflow, count, msg_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            exp_q.push_back(model_rd(i));
            @(negedge clk);
            got = rd_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ovf_keep[%0d]: got %h, want %h", i, got, exp);
            end
        end
        pulse_ack();
        vectors++;
        if (count !== 4'd0 || msg_ready !== 1'b0 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ack: got cnt=%0d rdy=%b ovf=%b, want 0 0 1", count, msg_ready, overflow);
        end
        write_byte(8'h61);
        pulse_ack();
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL ack_in_fill: got cnt=%0d, want 1", count);
        end
        // Index 7 now maps to the fresh slot 0, index 0 to the untouched slot 7.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rd_addr = (i == 0) ? 4'd7 : 4'd0;
            exp_q.push_back(model_rd(int'(rd_addr)));
            @(negedge clk);
            got = rd_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL fill_read[%0d]: got %h, want %h", rd_addr, got, exp);
            end
        end
        pulse_clear();
        vectors++;
        if (overflow !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL clear: got ovf=%b cnt=%0d, want 0 0", overflow, count);
        end
    endtask

    task automatic test_level_hold();
        @(negedge clk);
        rx_data     = 8'h4C;
        new_rx_data = 1'b1;
        repeat (5) @(negedge clk);
        new_rx_data = 1'b0;
        model_write(8'h4C);
        vectors++;
        if (count !== m_count) begin
            miscompares++;
            $display("FAIL level_hold: got cnt=%0d, want %0d", count, m_count);
        end
    endtask

    task automatic test_collisions();
        // clear and write together: clear wins, slot 0 keeps 'L'.
        @(negedge clk);
        clear = 1'b1; new_rx_data = 1'b1; rx_data = 8'h4B;
        @(negedge clk);
        clear = 1'b0; new_rx_data = 1'b0;
        m_count = 4'd0; m_ovf = 1'b0; m_ready = 1'b0;
        vectors++;
        if (count !== 4'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_wr: got cnt=%0d ovf=%b, want 0 0", count, overflow);
        end
        @(negedge clk);
        rd_addr = 4'd7;
        exp_q.push_back(model_rd(7));
        @(negedge clk);
        got = rd_data;
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL clear_wr_slot: got %h, want %h", got, exp);
        end
        for (int i = 0; i < 8; i++) write_byte(8'h61 + 8'(i));
        // rd_ack and write together in READY: ack taken, byte dropped.
        @(negedge clk);
        rd_ack = 1'b1; new_rx_data = 1'b1; rx_data = 8'h6B;
        @(negedge clk);
        rd_ack = 1'b0; new_rx_data = 1'b0;
        m_count = 4'd0; m_ready = 1'b0; m_ovf = 1'b1;
        vectors++;
        if (count !== 4'd0 || overflow !== 1'b1 || msg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_wr: got cnt=%0d ovf=%b rdy=%b, want 0 1 0", count, overflow, msg_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            exp_q.push_back(model_rd(i));
            @(negedge clk);
            got = rd_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ack_wr_keep[%0d]: got %h, want %h", i, got, exp);
            end
        end
        pulse_clear();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) write_byte(8'h31 + 8'(i));
        @(negedge clk);
        rd_addr = 4'd8;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (count !== 4'd0 || rd_data !== 8'h00 || msg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: got cnt=%0d rd=%h rdy=%b, want 0 00 0", count, rd_data, msg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        write_byte(8'h51);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rd_addr = (i == 0) ? 4'd7 : 4'd6;
            exp_q.push_back(model_rd(int'(rd_addr)));
            @(negedge clk);
            got = rd_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL post_rst[%0d]: got %h, want %h", rd_addr, got, exp);
            end
        end
        // Level already high at reset release counts as one write.
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        new_rx_data = 1'b1;
        rx_data = 8'h52;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        new_rx_data = 1'b0;
        model_write(8'h52);
        vectors++;
        if (count !== m_count) begin
            miscompares++;
            $display("FAIL level_at_release: got cnt=%0d, want %0d", count, m_count);
        end
    endtask

    task automatic test_depth4();
        logic [7:0] exp2 [5];
        exp2 = '{8'h77, 8'h78, 8'h79, 8'h7A, 8'h00};
        pulse_clear();
        for (int i = 0; i < 4; i++) write_byte(exp2[i]);
        vectors++;
        if (count2 !== 4'd4 || msg_ready2 !== 1'b1) begin
            miscompares++;
            $display("FAIL d4_full: got cnt=%0d rdy=%b, want 4 1", count2, msg_ready2);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_addr = 4'(i);
            exp_q.push_back(exp2[i]);
            @(negedge clk);
            got = rd_data2;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL d4_read[%0d]: got %h, want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_fill_reverse();
        test_overflow();
        test_level_hold();
        test_collisions();
        test_async_reset();
        test_depth4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
